// File: rtl/vga_src_sched.sv
// vga_src_sched
// Frame-aligned pixel-source scheduler. It sits between several pixel
// producers and the ready-driven data port of the VGA controller, in the
// pixel-clock domain.
//
// The scheduler tracks the raster position from the VGA ready strobe. It
// switches sources only at frame boundaries. It re-aligns the active source
// to that source's start-of-frame marker, and it shows the fill colour
// whenever no aligned pixel is available.
//
// Ports
//   clk_i          pixel clock
//   reset_n_i      asynchronous active-low reset
//   sel_i          requested source index (out-of-range values are ignored)
//   vga_ready_i    VGA controller consumes data_o this cycle
//   data_o         pixel to VGA, {r,g,b}
//   src_valid_i    per-source head pixel valid
//   src_sof_i      per-source head pixel is frame pixel (0,0)
//   src_data_i     per-source head pixel
//   src_yumi_o     per-source pop strobe (one-hot or zero)
//   active_src_o   source currently scheduled
//   locked_o       high while streaming (RUN)
//   frame_start_o  one-cycle pulse after the last pixel of a frame
//   err_cnt_o      saturating underrun/misalignment count
module vga_src_sched #(
  parameter int num_src_p    = 2,
  parameter int pixel_bits_p = 4,
  parameter int hpix_p       = 640,
  parameter int vpix_p       = 480,
  parameter logic [3*pixel_bits_p-1:0] fill_color_p = '0,
  parameter int err_bits_p   = 8,
  localparam int SEL_W = (num_src_p > 1) ? $clog2(num_src_p) : 1
) (
  input  logic                                          clk_i,
  input  logic                                          reset_n_i,
  input  logic [SEL_W-1:0]                              sel_i,
  input  logic                                          vga_ready_i,
  output logic [2:0][pixel_bits_p-1:0]                  data_o,
  input  logic [num_src_p-1:0]                          src_valid_i,
  input  logic [num_src_p-1:0]                          src_sof_i,
  input  logic [num_src_p-1:0][2:0][pixel_bits_p-1:0]   src_data_i,
  output logic [num_src_p-1:0]                          src_yumi_o,
  output logic [SEL_W-1:0]                              active_src_o,
  output logic                                          locked_o,
  output logic                                          frame_start_o,
  output logic [err_bits_p-1:0]                         err_cnt_o
);

  localparam int XW = (hpix_p > 1) ? $clog2(hpix_p) : 1;
  localparam int YW = (vpix_p > 1) ? $clog2(vpix_p) : 1;
  localparam logic [XW-1:0]  X_LAST    = XW'(hpix_p - 1);
  localparam logic [YW-1:0]  Y_LAST    = YW'(vpix_p - 1);
  localparam logic [SEL_W:0] NUM_SRC_W = (SEL_W + 1)'(num_src_p);

  typedef enum logic [1:0] {
    ST_DRAIN = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RUN   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [SEL_W-1:0]        r_active;
  logic [SEL_W-1:0]        r_pending;
  logic [XW-1:0]           r_x;
  logic [YW-1:0]           r_y;
  logic                    r_frame_start;
  logic [err_bits_p-1:0]   r_err;

  logic                    w_v;
  logic                    w_s;
  logic                    w_pos0;
  logic                    w_x_last;
  logic                    w_wrap;
  logic                    w_match;
  logic                    w_switch;
  logic                    w_sel_ok;
  logic                    w_err_inc;
  logic [num_src_p-1:0]    w_yumi;
  logic [2:0][pixel_bits_p-1:0] w_data;

  assign w_v      = src_valid_i[r_active];
  assign w_s      = src_sof_i[r_active];
  assign w_pos0   = (r_x == '0) && (r_y == '0);
  assign w_x_last = (r_x == X_LAST);
  assign w_wrap   = vga_ready_i && w_x_last && (r_y == Y_LAST);
  // A head pixel is in step with the raster when its sof flag agrees with
  // whether the raster is at (0,0).
  assign w_match  = w_v && (w_s == w_pos0);
  assign w_switch = w_wrap && (r_pending != r_active);
  assign w_sel_ok = ({1'b0, sel_i} < NUM_SRC_W);

  always_comb begin
    w_state_nxt = r_state;
    w_yumi      = '0;
    w_data      = fill_color_p;
    w_err_inc   = 1'b0;
    case (r_state)
      ST_DRAIN: begin
        // Discard mid-frame pixels until the source presents its sof pixel.
        // This does not wait for the VGA ready strobe.
        w_yumi[r_active] = w_v & ~w_s;
        if (w_v && w_s) begin
          w_state_nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // Hold the sof pixel at the head until the raster reaches (0,0).
        if (!w_v) begin
          w_state_nxt = ST_DRAIN;
        end else if (w_wrap) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        // A misaligned pixel is never shown on a consuming cycle.
        if (w_v && !(vga_ready_i && !w_match)) begin
          w_data = src_data_i[r_active];
        end
        if (vga_ready_i) begin
          if (w_match) begin
            w_yumi[r_active] = 1'b1;
          end else begin
            w_err_inc   = 1'b1;
            w_state_nxt = ST_DRAIN;
          end
        end
      end
      default: w_state_nxt = ST_DRAIN;
    endcase
    // A source change at the frame boundary always restarts alignment.
    if (w_switch) begin
      w_state_nxt = ST_DRAIN;
    end
    // No pops may leak out while reset is held.
    if (!reset_n_i) begin
      w_yumi = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state       <= ST_DRAIN;
      r_active      <= '0;
      r_pending     <= '0;
      r_x           <= '0;
      r_y           <= '0;
      r_frame_start <= 1'b0;
      r_err         <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_frame_start <= w_wrap;
      if (w_sel_ok) begin
        r_pending <= sel_i;
      end
      if (w_switch) begin
        r_active <= r_pending;
      end
      if (vga_ready_i) begin
        if (w_x_last) begin
          r_x <= '0;
          r_y <= (r_y == Y_LAST) ? '0 : r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
      if (w_err_inc && (r_err != '1)) begin
        r_err <= r_err + 1'b1;
      end
    end
  end

  assign data_o        = w_data;
  assign src_yumi_o    = w_yumi;
  assign active_src_o  = r_active;
  assign locked_o      = (r_state == ST_RUN);
  assign frame_start_o = r_frame_start;
  assign err_cnt_o     = r_err;

endmodule

// File: tb/tb_vga_src_sched.sv
// Testbench for vga_src_sched. It uses a 4x2 raster (8 pixels per frame) and
// three sources. Each source is a counting stream whose sof marker falls
// every 8 pixels at a per-source offset.
module tb_vga_src_sched;

  localparam int NS = 3;
  localparam int PB = 4;
  localparam logic [11:0] FILL = 12'hA5C;

  logic                    clk = 1'b0;
  logic                    reset_n = 1'b0;
  logic [1:0]              sel = 2'd0;
  logic                    ready = 1'b0;
  logic [2:0][PB-1:0]      data_o;
  logic [NS-1:0]           valid = '0;
  logic [NS-1:0]           sof;
  logic [NS-1:0]           sof_clr = '0;
  logic [NS-1:0]           sof_set = '0;
  logic [NS-1:0][2:0][PB-1:0] sdata;
  logic [NS-1:0]           yumi;
  logic [1:0]              active;
  logic                    locked;
  logic                    fs;
  logic [7:0]              err;

  logic [7:0] k [NS];
  int         off [NS] = '{0, 3, 0};
  int         n_chk = 0;
  int         n_err = 0;
  int         cyc = 0;

  vga_src_sched #(
    .num_src_p(NS), .pixel_bits_p(PB), .hpix_p(4), .vpix_p(2),
    .fill_color_p(FILL), .err_bits_p(8)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n), .sel_i(sel), .vga_ready_i(ready),
    .data_o(data_o), .src_valid_i(valid), .src_sof_i(sof),
    .src_data_i(sdata), .src_yumi_o(yumi), .active_src_o(active),
    .locked_o(locked), .frame_start_o(fs), .err_cnt_o(err)
  );

  always #5 clk = ~clk;

  // Source streams: the head index advances on each pop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NS; i++) k[i] <= 8'd0;
    end else begin
      for (int i = 0; i < NS; i++) if (yumi[i]) k[i] <= k[i] + 8'd1;
    end
  end

  always_comb begin
    sof   = '0;
    sdata = '0;
    for (int i = 0; i < NS; i++) begin
      sdata[i] = {4'(i + 1), k[i]};
      sof[i]   = sof_set[i] |
                 (~sof_clr[i] & (((k[i] + 8'(off[i])) & 8'd7) == 8'd0));
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  int pops;
  int bad;
  int first;

  initial begin
    // Reset state. With source 0 valid and no sof, DRAIN would pop unless
    // the pop is forced low during reset.
    valid   = 3'b001;
    sof_clr = 3'b001;
    repeat (2) @(posedge clk);
    #1;
    check("rst_yumi",   32'(yumi),   32'h0);
    check("rst_data",   32'(data_o), 32'(FILL));
    check("rst_locked", 32'(locked), 32'h0);
    check("rst_active", 32'(active), 32'h0);
    check("rst_fs",     32'(fs),     32'h0);
    check("rst_err",    32'(err),    32'h0);

    // Aligned source 0: sof is at the head on release, so there are no DRAIN pops.
    sof_clr = '0;
    valid   = 3'b011;
    ready   = 1'b1;
    reset_n = 1'b1;
    cyc     = 0;
    #1;
    check("drain_hold_sof", 32'(yumi),   32'h0);
    check("drain_locked",   32'(locked), 32'h0);
    step();                                  // E1: WAIT
    check("wait_locked", 32'(locked), 32'h0);
    check("wait_data",   32'(data_o), 32'(FILL));
    check("wait_yumi",   32'(yumi),   32'h0);
    repeat (6) step();                       // E7
    check("wait_fs_low", 32'(fs), 32'h0);
    step();                                  // E8: RUN at (0,0)
    check("run_locked", 32'(locked), 32'h1);
    check("run_data0",  32'(data_o), 32'h100);
    check("run_yumi0",  32'(yumi),   32'h1);
    check("run_fs",     32'(fs),     32'h1);
    pops = int'(yumi[0]);
    step();                                  // E9
    check("fs_pulse_one", 32'(fs), 32'h0);
    pops += int'(yumi[0]);
    for (int i = 0; i < 6; i++) begin
      step();
      pops += int'(yumi[0]);
    end                                      // E15
    check("pops_per_frame", 32'(pops), 32'd8);
    step();                                  // E16
    check("fs_second",  32'(fs),     32'h1);
    check("run_data8",  32'(data_o), 32'h108);
    check("err_clean",  32'(err),    32'h0);

    // Underrun at x=2,y=1.
    repeat (6) step();                       // E22
    valid = 3'b010;
    #1;
    check("udr_data",   32'(data_o), 32'(FILL));
    check("udr_yumi",   32'(yumi),   32'h0);
    check("udr_locked", 32'(locked), 32'h1);
    step();                                  // E23: DRAIN
    check("udr_err",    32'(err),    32'h1);
    check("udr_drain",  32'(locked), 32'h0);
    valid = 3'b011;
    #1;
    check("drain_pop", 32'(yumi), 32'h1);    // head k=14
    pops = int'(yumi[0]);
    step();                                  // E24
    check("fs_after_udr", 32'(fs), 32'h1);
    pops += int'(yumi[0]);
    step();                                  // E25: head k=16 carries sof
    check("drain_pops", 32'(pops), 32'd2);
    check("drain_stop", 32'(yumi), 32'h0);
    step();                                  // E26: WAIT
    check("relock_wait", 32'(locked), 32'h0);
    repeat (6) step();                       // E32
    check("relock_run",  32'(locked), 32'h1);
    check("relock_data", 32'(data_o), 32'h110);

    // Source switch requested mid-frame.
    step();                                  // E33
    sel = 2'd1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (active != 2'd0 || yumi[1]) bad++;
    end                                      // E39
    check("no_early_switch", 32'(bad),    32'd0);
    check("old_last_pop",    32'(yumi),   32'h1);
    step();                                  // E40
    check("sw_active", 32'(active), 32'h1);
    check("sw_drain",  32'(locked), 32'h0);
    check("sw_fs",     32'(fs),     32'h1);
    check("sw_yumi",   32'(yumi),   32'h2);
    repeat (5) step();                       // E45: source 1 at sof
    check("sw_sof_hold", 32'(yumi), 32'h0);
    repeat (3) step();                       // E48
    check("sw_run",      32'(locked), 32'h1);
    check("sw_run_data", 32'(data_o), 32'h205);
    check("sw_run_yumi", 32'(yumi),   32'h2);

    // Out-of-range select is ignored across a wrap.
    sel = 2'd3;
    repeat (8) step();                       // E56
    check("sel3_active", 32'(active), 32'h1);
    check("sel3_locked", 32'(locked), 32'h1);
    check("sel3_data",   32'(data_o), 32'h20D);

    // Misalignment every frame until the counter saturates.
    sof_set = 3'b010;
    step();                                  // E57: sof at x=1
    check("mis_yumi", 32'(yumi),   32'h0);
    check("mis_data", 32'(data_o), 32'(FILL));
    step();
    check("mis_err2", 32'(err), 32'd2);
    repeat (8) step();
    check("mis_err3", 32'(err), 32'd3);
    repeat (2400) step();
    check("err_sat", 32'(err), 32'd255);
    sof_set = '0;

    // Reset in the middle of RUN at x=2,y=1.
    repeat (32) step();
    for (int i = 0; i < 8 && (cyc % 8) != 6; i++) step();
    check("pre_rst_pos",    32'(cyc % 8), 32'd6);
    check("pre_rst_locked", 32'(locked),  32'h1);
    reset_n = 1'b0;
    #1;
    check("arst_yumi",   32'(yumi),   32'h0);
    check("arst_err",    32'(err),    32'h0);
    check("arst_locked", 32'(locked), 32'h0);
    check("arst_active", 32'(active), 32'h0);
    check("arst_data",   32'(data_o), 32'(FILL));
    repeat (2) @(posedge clk);
    #1;
    sel     = 2'd0;
    reset_n = 1'b1;
    cyc     = 0;
    first   = -1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (fs && first < 0) first = i;
    end
    check("raster_restart", 32'(first), 32'd8);
    check("post_rst_err",   32'(err),   32'h0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
